mult_sequenciador: RTL and testbench

Operand sequencer sitting directly upstream of the 4x4 shift-add multiplier. It buffers operand pairs from a producer in a small FIFO and issues them one at a time to the multiplier with a one-cycle start pulse. It captures each product on the multiplier's `Done`, then presents the result to a consumer over a valid/ready handshake. A watchdog flags multiplier hangs.

---
 rtl/mult_sequenciador.sv | 182 ++++++++++++++++++
 tb/tb_mult_sequenciador.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequenciador.sv
// Operand sequencer for the 4x4 shift-add multiplier: pair FIFO, issue FSM, result slot and watchdog.
// Optional result accumulator enabled by defining MULT_SEQ_ACCUM_EN.
module mult_sequenciador #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [3:0]                  In_A,
  input  logic [3:0]                  In_B,
  output logic                        Mul_St,
  output logic [3:0]                  Mul_A,
  output logic [3:0]                  Mul_B,
  input  logic                        Mul_Done,
  input  logic                        Mul_Idle,
  input  logic [7:0]                  Mul_Produto,
  input  logic                        Acc_Clr,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [11:0]                 Out_Dado,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Busy,
  output logic                        Timeout_Err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    mem_a_r [FIFO_DEPTH];
  logic [3:0]    mem_b_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [7:0]    wd_r;
  logic          done_q_r;
  logic          push_s;
  logic          pop_s;
  logic          done_edge_s;
  logic          capture_s;
  logic [11:0]   result_s;

  // In_Ready looks only at the current occupancy, so a full FIFO never admits a push on a pop edge.
  assign In_Ready    = !Rst && (Count < DEPTH_C);
  assign Busy        = (state_r != ST_IDLE) || (Count != {CW{1'b0}});
  assign push_s      = In_Valid && In_Ready;
  assign pop_s       = (state_r == ST_IDLE) && (Count != {CW{1'b0}}) && Mul_Idle && !Out_Valid;
  assign done_edge_s = Mul_Done && !done_q_r;
  assign capture_s   = (state_r == ST_WAIT) && done_edge_s;

`ifdef MULT_SEQ_ACCUM_EN
  logic [11:0] acc_r;
  logic [11:0] acc_base_s;

  // Clear takes effect before the add when both land on the same edge.
  always_comb begin
    if (Acc_Clr) begin
      acc_base_s = 12'd0;
    end else begin
      acc_base_s = acc_r;
    end
    result_s = acc_base_s + {4'd0, Mul_Produto};
  end

  // Accumulator register, wraps modulo 4096.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_r <= 12'd0;
    end else if (capture_s) begin
      acc_r <= result_s;
    end else if (Acc_Clr) begin
      acc_r <= 12'd0;
    end else begin
      acc_r <= acc_r;
    end
  end
`else
  logic acc_clr_unused_s;

  assign acc_clr_unused_s = Acc_Clr;
  assign result_s         = {4'd0, Mul_Produto};
`endif

  // FIFO storage; only ever read behind a written slot, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_a_r[wr_ptr_r] <= In_A;
      mem_b_r[wr_ptr_r] <= In_B;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      Count    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Done history; resets high so a Done still asserted out of reset is not seen as an edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      done_q_r <= 1'b1;
    end else begin
      done_q_r <= Mul_Done;
    end
  end

  // Issue FSM with watchdog, result slot and sticky timeout flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      Mul_St      <= 1'b0;
      Mul_A       <= 4'd0;
      Mul_B       <= 4'd0;
      Out_Valid   <= 1'b0;
      Out_Dado    <= 12'd0;
      Timeout_Err <= 1'b0;
      wd_r        <= 8'd0;
    end else begin
      Mul_St <= 1'b0;
      if (Out_Valid && Out_Ready) begin
        Out_Valid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          wd_r <= 8'd0;
          if (pop_s) begin
            Mul_A   <= mem_a_r[rd_ptr_r];
            Mul_B   <= mem_b_r[rd_ptr_r];
            Mul_St  <= 1'b1;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          wd_r    <= 8'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge_s) begin
            Out_Dado  <= result_s;
            Out_Valid <= 1'b1;
            wd_r      <= 8'd0;
            state_r   <= ST_IDLE;
          end else if ((wd_r + 8'd1) == TIMEOUT_C) begin
            Timeout_Err <= 1'b1;
            wd_r        <= 8'd0;
            state_r     <= ST_IDLE;
          end else begin
            wd_r <= wd_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequenciador.sv
// Directed bench for mult_sequenciador with a behavioural shift-add multiplier responder.
module tb_mult_sequenciador;

  localparam int LAT = 4;
  localparam int TMO = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_a = 4'd0;
  logic [3:0]  in_b = 4'd0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        mul_st;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic        mul_done;
  logic        mul_idle;
  logic        out_valid;
  logic [11:0] out_dado;
  logic [2:0]  count;
  logic        busy;
  logic        timeout_err;

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [3:0]  m_a = 4'd0;
  logic [3:0]  m_b = 4'd0;
  logic [7:0]  m_prod = 8'd0;
  int          m_cnt = 0;
  logic        stall = 1'b0;
  logic        hang = 1'b0;
  logic        done_hi = 1'b0;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          st_run = 0;
  int          res_q[$];
  int          st_w_q[$];

  mult_sequenciador #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .Clk(clk), .Rst(rst),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_A(in_a), .In_B(in_b),
    .Mul_St(mul_st), .Mul_A(mul_a), .Mul_B(mul_b),
    .Mul_Done(mul_done), .Mul_Idle(mul_idle), .Mul_Produto(m_prod),
    .Acc_Clr(acc_clr),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Dado(out_dado),
    .Count(count), .Busy(busy), .Timeout_Err(timeout_err)
  );

  always #5 clk = ~clk;

  assign mul_done = m_done | done_hi;
  assign mul_idle = !m_busy && !stall;

  // Multiplier responder: LAT cycles after a start it goes idle and raises Done until the next start.
  always @(posedge clk) begin
    if (mul_st && !m_busy) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= LAT;
      m_a    <= mul_a;
      m_b    <= mul_b;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (!hang) begin
          m_done <= 1'b1;
          m_prod <= m_a * m_b;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Record accepted results and start-pulse widths.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) res_q.push_back(int'(out_dado));
    if (mul_st) begin
      st_run++;
    end else if (st_run > 0) begin
      st_w_q.push_back(st_run);
      st_run = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    check_val("push_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 300 && res_q.size() < n; i++) tick(1);
    check_val(tag, res_q.size(), n);
  endtask

  function automatic int get_res(input int i);
    if (i < res_q.size()) return res_q[i];
    return -1;
  endfunction

  initial begin
    int n_st0;
    int exp1[3];
`ifdef MULT_SEQ_ACCUM_EN
    exp1 = '{15, 64, 100};
`else
    exp1 = '{15, 49, 36};
`endif

    // Reset values while Rst is high.
    tick(3);
    @(negedge clk);
    check_val("rst_mul_st", mul_st, 0);
    check_val("rst_mul_a", mul_a, 0);
    check_val("rst_mul_b", mul_b, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_dado", out_dado, 0);
    check_val("rst_count", count, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_timeout", timeout_err, 0);
    check_val("rst_in_ready", in_ready, 0);
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_rst", in_ready, 1);
    tick(1);

    // Basic issue timing and three products.
    push(4'd3, 4'd5);
    @(negedge clk);
    check_val("t1_count_after_push", count, 1);
    check_val("t1_st_before", mul_st, 0);
    tick(1);
    @(negedge clk);
    check_val("t1_st_pulse", mul_st, 1);
    check_val("t1_mul_a", mul_a, 3);
    check_val("t1_mul_b", mul_b, 5);
    check_val("t1_count_after_pop", count, 0);
    check_val("t1_busy", busy, 1);
    tick(1);
    @(negedge clk);
    check_val("t1_st_after", mul_st, 0);
    tick(1);
    push(4'd7, 4'd7);
    push(4'd12, 4'd3);
    wait_results("t1_nres", 3);
    for (int i = 0; i < 3; i++) check_val($sformatf("t1_res%0d", i), get_res(i), exp1[i]);
    tick(2);
    check_val("t1_nst", st_w_q.size(), 3);
    for (int i = 0; i < st_w_q.size(); i++) check_val($sformatf("t1_st_w%0d", i), st_w_q[i], 1);

    // Accumulator clear coinciding with capture; Acc_Clr stays high afterwards.
    acc_clr = 1'b1;
    push(4'd2, 4'd3);
    wait_results("acc_nres", 4);
    check_val("acc_clr_res", get_res(3), 6);

    // FIFO fill with the multiplier stalled.
    stall = 1'b1;
    push(4'd1, 4'd2);
    push(4'd2, 4'd3);
    push(4'd4, 4'd4);
    push(4'd9, 4'd9);
    @(negedge clk);
    check_val("t2_count_full", count, 4);
    check_val("t2_in_ready_full", in_ready, 0);
    check_val("t2_busy", busy, 1);
    in_valid = 1'b1;
    in_a = 4'd15;
    in_b = 4'd1;
    tick(5);
    @(negedge clk);
    check_val("t2_count_held", count, 4);
    stall = 1'b0;
    push(4'd15, 4'd1);
    wait_results("t2_nres", 9);
    check_val("t2_res0", get_res(4), 2);
    check_val("t2_res1", get_res(5), 6);
    check_val("t2_res2", get_res(6), 16);
    check_val("t2_res3", get_res(7), 81);
    check_val("t2_res4", get_res(8), 15);
    tick(2);

    // Output back-pressure blocks the next start.
    out_ready = 1'b0;
    n_st0 = st_w_q.size();
    push(4'd15, 4'd15);
    tick(10);
    push(4'd2, 4'd2);
    tick(10);
    @(negedge clk);
    check_val("t3_valid_held", out_valid, 1);
    check_val("t3_dado_held", out_dado, 225);
    check_val("t3_one_start", st_w_q.size() + ((st_run > 0) ? 1 : 0), n_st0 + 1);
    check_val("t3_count_pending", count, 1);
    tick(1);
    out_ready = 1'b1;
    wait_results("t3_nres", 11);
    check_val("t3_res0", get_res(9), 225);
    check_val("t3_res1", get_res(10), 4);
    tick(2);

    // Watchdog: multiplier never raises Done.
    hang = 1'b1;
    push(4'd5, 4'd5);
    tick(TMO + 1);
    @(negedge clk);
    check_val("t4_tmo_early", timeout_err, 0);
    check_val("t4_busy_wait", busy, 1);
    tick(1);
    @(negedge clk);
    check_val("t4_tmo_set", timeout_err, 1);
    check_val("t4_busy_idle", busy, 0);
    check_val("t4_no_valid", out_valid, 0);
    hang = 1'b0;
    push(4'd6, 4'd7);
    wait_results("t4_nres", 12);
    check_val("t4_res", get_res(11), 42);
    check_val("t4_tmo_sticky", timeout_err, 1);
    tick(2);

    // Reset during WAIT with Done held high.
    hang = 1'b1;
    push(4'd3, 4'd3);
    tick(3);
    push(4'd1, 4'd1);
    tick(3);
    done_hi = 1'b1;
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    check_val("t5_mul_st", mul_st, 0);
    check_val("t5_mul_a", mul_a, 0);
    check_val("t5_mul_b", mul_b, 0);
    check_val("t5_out_valid", out_valid, 0);
    check_val("t5_out_dado", out_dado, 0);
    check_val("t5_count", count, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_timeout", timeout_err, 0);
    check_val("t5_in_ready", in_ready, 0);
    tick(1);
    rst = 1'b0;
    tick(10);
    @(negedge clk);
    check_val("t5_no_spurious", out_valid, 0);
    check_val("t5_busy_after", busy, 0);
    check_val("t5_res_count", res_q.size(), 12);
    tick(1);
    done_hi = 1'b0;
    hang = 1'b0;
    push(4'd4, 4'd5);
    wait_results("t5_nres", 13);
    check_val("t5_res", get_res(12), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
